axil_reg_ctrl: RTL and testbench
================================

Name: axil_reg_ctrl

Overview:
AXI4-Lite slave front-end that sequences all accesses to the peripheral register bank (LED, 7-segment, IRQ status, reserved words at 0x00–0x0C). It captures the AW, W and AR channels independently and serialises reads and writes onto the bank's wr_en/rd_en ports, one access at a time, with round-robin arbitration. It also generates B and R responses, including SLVERR for unaligned addresses.

Parameters:
ADDR_WIDTH, 4, byte-address width of both the AXI and bank address buses.
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assertion, active-low
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
bank_wr_en  out  1  single-cycle bank write strobe
bank_wr_addr  out  ADDR_WIDTH  bank write address
bank_wr_data  out  DATA_WIDTH  bank write data
bank_wr_strb  out  DATA_WIDTH/8  bank byte enables
bank_rd_en  out  1  single-cycle bank read strobe
bank_rd_addr  out  ADDR_WIDTH  bank read address
bank_rd_data  in  DATA_WIDTH  bank read data
bank_rd_valid  in  1  bank read data valid; arrives one cycle after bank_rd_en

Behaviour:
- Reset:
  - All outputs are 0, except awready, wready and arready, which are 1.
  - Capture flags aw_full, w_full and ar_full are cleared.
  - FSM goes to IDLE; last_grant = READ, so the first tie goes to write.
- Capture:
  - awready = !aw_full, wready = !w_full, arready = !ar_full.
  - A handshake latches address/data/strobe and sets the flag the next cycle.
  - AW and W may complete in either order or in the same cycle.
  - aw_full and w_full clear on the B handshake; ar_full clears on the R handshake.
  - At most one outstanding write and one outstanding read.
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
- IDLE arbitration:
  - wr_req = aw_full & w_full & !bvalid; rd_req = ar_full & !rvalid.
  - Only one request present -> it is granted.
  - Both present -> grant the opposite of last_grant.
  - last_grant updates on every grant.
- Write path:
  - Grant, aligned (awaddr[1:0]==0) -> WR_EXEC: bank_wr_en=1 for exactly one cycle with the latched addr/data/strb. Next cycle -> WR_RESP with bvalid=1, bresp=00.
  - Grant, unaligned -> no bank access; straight to WR_RESP with bresp=10.
  - WR_RESP holds bvalid until bready, then returns to IDLE.
- Read path:
  - Grant, aligned -> RD_EXEC: bank_rd_en=1 for one cycle. Then RD_WAIT until bank_rd_valid; capture bank_rd_data into rdata; go to RD_RESP with rvalid=1, rresp=00.
  - Grant, unaligned -> no bank access; RD_RESP with rdata=0, rresp=10.
  - rdata/rresp stay stable while rvalid=1 && !rready; return to IDLE on the handshake.
- Latency, zero backpressure, handshake in cycle 0:
  - Write: wr_en in cycle 2, bvalid in cycle 3.
  - Read: rd_en in cycle 2, rvalid in cycle 4.
- Bank strobes: bank_wr_en and bank_rd_en are never asserted in the same cycle. Bank address/data outputs are don't-care while the strobes are low, but are held at their last value.
- Reset mid-transaction: abandon immediately; no further bank strobe; all valids drop asynchronously.

Test Plan:
- Reset then idle -> awready=wready=arready=1; bvalid=rvalid=bank_wr_en=bank_rd_en=0.
- AW(0x04) and W(0x0000ABCD, strb 0xF) in the same cycle, bready=1 -> bank_wr_en one cycle, 2 cycles later, addr 0x04, data 0x0000ABCD; bvalid next cycle, bresp=00.
- W one cycle before AW(0x00, data 0x5) -> single bank write of 0x5 at 0x00; then AR(0x00) -> bank_rd_en, rvalid 4 cycles after AR handshake, rdata=0x5.
- Write (0x08) and read (0x0C) both pending in IDLE after reset -> write granted first, read second. Repeat with both pending -> read granted first (alternation).
- AR(0x02) -> no bank_rd_en; rresp=10, rdata=0. AW(0x07)+W -> no bank_wr_en; bresp=10.
- rready held 0 for 5 cycles -> rvalid/rdata stable, arready stays 0. Assert rst_n=0 during WR_EXEC -> all valids 0 immediately, no wr_en after release.

Source files
------------

// File: rtl/axil_reg_ctrl_if.sv
// AXI4-Lite channel bundle between a bus master and the register-bank front-end.
// The slave modport is the view taken by axil_reg_ctrl.
interface axil_reg_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_reg_ctrl.sv
// AXI4-Lite slave front-end: captures AW/W/AR independently and serialises one
// access at a time onto the register bank, round-robin between reads and writes.
module axil_reg_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axil_reg_ctrl_if.slave          s_axi,
    output logic                    bank_wr_en,
    output logic [ADDR_WIDTH-1:0]   bank_wr_addr,
    output logic [DATA_WIDTH-1:0]   bank_wr_data,
    output logic [DATA_WIDTH/8-1:0] bank_wr_strb,
    output logic                    bank_rd_en,
    output logic [ADDR_WIDTH-1:0]   bank_rd_addr,
    input  logic [DATA_WIDTH-1:0]   bank_rd_data,
    input  logic                    bank_rd_valid
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP} state_t;
    typedef enum logic {GNT_WR, GNT_RD} grant_t;

    state_t                  state_q, state_d;
    grant_t                  last_grant_q, last_grant_d;
    logic                    aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   bank_wr_addr_q, bank_rd_addr_q;
    logic [DATA_WIDTH-1:0]   bank_wr_data_q;
    logic [STRB_WIDTH-1:0]   bank_wr_strb_q;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic bvalid, rvalid, wr_req, rd_req, grant_wr, grant_rd;
    logic wr_aligned, rd_aligned;

    assign bvalid     = (state_q == WR_RESP);
    assign rvalid     = (state_q == RD_RESP);
    assign aw_hs      = s_axi.s_axi_awvalid & ~aw_full_q;
    assign w_hs       = s_axi.s_axi_wvalid & ~w_full_q;
    assign ar_hs      = s_axi.s_axi_arvalid & ~ar_full_q;
    assign b_hs       = bvalid & s_axi.s_axi_bready;
    assign r_hs       = rvalid & s_axi.s_axi_rready;
    assign wr_req     = aw_full_q & w_full_q & ~bvalid;
    assign rd_req     = ar_full_q & ~rvalid;
    assign wr_aligned = (awaddr_q[1:0] == 2'b00);
    assign rd_aligned = (araddr_q[1:0] == 2'b00);

    // On a tie the side that did not win last time gets the bank.
    assign grant_wr = (state_q == IDLE) & wr_req & (~rd_req | (last_grant_q == GNT_RD));
    assign grant_rd = (state_q == IDLE) & rd_req & ~grant_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
        end else begin
            if (aw_hs) begin
                awaddr_q  <= s_axi.s_axi_awaddr;
                aw_full_q <= 1'b1;
            end else if (b_hs) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                wdata_q  <= s_axi.s_axi_wdata;
                wstrb_q  <= s_axi.s_axi_wstrb;
                w_full_q <= 1'b1;
            end else if (b_hs) begin
                w_full_q <= 1'b0;
            end
            if (ar_hs) begin
                araddr_q  <= s_axi.s_axi_araddr;
                ar_full_q <= 1'b1;
            end else if (r_hs) begin
                ar_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_RD;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    last_grant_d = GNT_WR;
                    state_d      = wr_aligned ? WR_EXEC : WR_RESP;
                end else if (grant_rd) begin
                    last_grant_d = GNT_RD;
                    state_d      = rd_aligned ? RD_EXEC : RD_RESP;
                end
            end
            WR_EXEC: state_d = WR_RESP;
            WR_RESP: if (s_axi.s_axi_bready) state_d = IDLE;
            RD_EXEC: state_d = RD_WAIT;
            RD_WAIT: if (bank_rd_valid) state_d = RD_RESP;
            RD_RESP: if (s_axi.s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response and bank-side registers only move at grant / bank return, so they
    // stay stable through backpressure and hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bresp_q        <= RESP_OKAY;
            rresp_q        <= RESP_OKAY;
            rdata_q        <= '0;
            bank_wr_addr_q <= '0;
            bank_wr_data_q <= '0;
            bank_wr_strb_q <= '0;
            bank_rd_addr_q <= '0;
        end else begin
            if (grant_wr) begin
                bresp_q <= wr_aligned ? RESP_OKAY : RESP_SLVERR;
                if (wr_aligned) begin
                    bank_wr_addr_q <= awaddr_q;
                    bank_wr_data_q <= wdata_q;
                    bank_wr_strb_q <= wstrb_q;
                end
            end
            if (grant_rd) begin
                rresp_q <= rd_aligned ? RESP_OKAY : RESP_SLVERR;
                if (rd_aligned) begin
                    bank_rd_addr_q <= araddr_q;
                end else begin
                    rdata_q <= '0;
                end
            end
            if ((state_q == RD_WAIT) && bank_rd_valid) begin
                rdata_q <= bank_rd_data;
            end
        end
    end

    assign s_axi.s_axi_awready = ~aw_full_q;
    assign s_axi.s_axi_wready  = ~w_full_q;
    assign s_axi.s_axi_arready = ~ar_full_q;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_rdata   = rdata_q;

    assign bank_wr_en   = (state_q == WR_EXEC);
    assign bank_rd_en   = (state_q == RD_EXEC);
    assign bank_wr_addr = bank_wr_addr_q;
    assign bank_wr_data = bank_wr_data_q;
    assign bank_wr_strb = bank_wr_strb_q;
    assign bank_rd_addr = bank_rd_addr_q;
endmodule

// File: tb/tb_axil_reg_ctrl.sv
// Directed bench for axil_reg_ctrl: a small register-bank model on the bank side,
// a vector table for single accesses and hand-written multi-cycle sequences.
module tb_axil_reg_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_reg_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

    logic        bank_wr_en, bank_rd_en, bank_rd_valid;
    logic [3:0]  bank_wr_addr, bank_rd_addr, bank_wr_strb;
    logic [31:0] bank_wr_data, bank_rd_data;

    axil_reg_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axi        (axi),
        .bank_wr_en   (bank_wr_en),
        .bank_wr_addr (bank_wr_addr),
        .bank_wr_data (bank_wr_data),
        .bank_wr_strb (bank_wr_strb),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_addr (bank_rd_addr),
        .bank_rd_data (bank_rd_data),
        .bank_rd_valid(bank_rd_valid)
    );

    // Register bank model: byte-enabled writes, read data one cycle after rd_en.
    logic [31:0] mem [4];
    always @(posedge clk) begin
        if (bank_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (bank_wr_strb[b]) mem[bank_wr_addr[3:2]][8*b +: 8] <= bank_wr_data[8*b +: 8];
        end
        bank_rd_valid <= bank_rd_en;
        if (bank_rd_en) bank_rd_data <= mem[bank_rd_addr[3:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int          wr_cnt = 0, rd_cnt = 0, wr_cyc = -1, rd_cyc = -1, overlap = 0;
    logic [3:0]  wr_addr_seen, wr_strb_seen;
    logic [31:0] wr_data_seen;
    int          ev_q[$];
    always @(negedge clk) begin
        if (bank_wr_en) begin
            wr_cnt++;
            wr_cyc       = cyc;
            wr_addr_seen = bank_wr_addr;
            wr_data_seen = bank_wr_data;
            wr_strb_seen = bank_wr_strb;
            ev_q.push_back(0);
        end
        if (bank_rd_en) begin
            rd_cnt++;
            rd_cyc = cyc;
            ev_q.push_back(1);
        end
        if (bank_wr_en && bank_rd_en) overlap++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a negedge; AW and W presented in the same cycle.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int hs_cyc, output int b_cyc);
        axi.s_axi_awaddr  = a;
        axi.s_axi_wdata   = d;
        axi.s_axi_wstrb   = s;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        b_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (axi.s_axi_bvalid) begin
                b_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("bvalid_seen", 32'(b_cyc >= 0), 32'd1);
        resp = axi.s_axi_bresp;
        @(negedge clk);
        $display("WR addr=0x%0h data=0x%08h strb=0x%0h bresp=%0d", a, d, s, resp);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [1:0] resp, output logic [31:0] data,
                           output int hs_cyc, output int r_cyc);
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        r_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (axi.s_axi_rvalid) begin
                r_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("rvalid_seen", 32'(r_cyc >= 0), 32'd1);
        resp = axi.s_axi_rresp;
        data = axi.s_axi_rdata;
        @(negedge clk);
        $display("RD addr=0x%0h rdata=0x%08h rresp=%0d", a, data, resp);
    endtask

    typedef struct {
        logic        is_rd;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic        exp_access;
        logic [31:0] exp_rdata;
    } vec_t;
    localparam int NV = 12;
    vec_t vecs [NV];

    logic [1:0]  resp;
    logic [31:0] rdat;
    int          hs, done, w0, r0, snap, e0, e1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // State of the bank model when the table runs: [0]=5 [1]=ABCD [2]=12345678 [3]=0C0C0C0C
        vecs[0]  = '{1'b0, 4'h4, 32'h11223344, 4'hF, 2'b00, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h0,        4'h0, 2'b00, 1'b1, 32'h11223344};
        vecs[2]  = '{1'b0, 4'h8, 32'hAABBCCDD, 4'h5, 2'b00, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 4'h8, 32'h0,        4'h0, 2'b00, 1'b1, 32'h12BB56DD};
        vecs[4]  = '{1'b0, 4'hC, 32'hFFFFFFFF, 4'h8, 2'b00, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 4'hC, 32'h0,        4'h0, 2'b00, 1'b1, 32'hFF0C0C0C};
        vecs[6]  = '{1'b1, 4'h2, 32'h0,        4'h0, 2'b10, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'h7, 32'hDEADBEEF, 4'hF, 2'b10, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b00, 1'b1, 32'h00000005};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000AA00, 4'h2, 2'b00, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 32'h0,        4'h0, 2'b00, 1'b1, 32'h0000AA05};
        vecs[11] = '{1'b1, 4'hD, 32'h0,        4'h0, 2'b10, 1'b0, 32'h0};

        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_bready = 1'b1; axi.s_axi_rready = 1'b1;

        // Reset and idle state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_awready", 32'(axi.s_axi_awready), 32'd1);
        chk("rst_wready",  32'(axi.s_axi_wready),  32'd1);
        chk("rst_arready", 32'(axi.s_axi_arready), 32'd1);
        chk("rst_bvalid",  32'(axi.s_axi_bvalid),  32'd0);
        chk("rst_rvalid",  32'(axi.s_axi_rvalid),  32'd0);
        chk("rst_wr_en",   32'(bank_wr_en),        32'd0);
        chk("rst_rd_en",   32'(bank_rd_en),        32'd0);

        // AW+W same cycle: wr_en two cycles later, bvalid three cycles later
        w0 = wr_cnt;
        do_write(4'h4, 32'h0000ABCD, 4'hF, resp, hs, done);
        chk("lat_wr_cnt",  32'(wr_cnt - w0), 32'd1);
        chk("lat_wr_cyc",  32'(wr_cyc - hs), 32'd2);
        chk("lat_b_cyc",   32'(done - hs),   32'd3);
        chk("lat_wr_addr", 32'(wr_addr_seen), 32'h4);
        chk("lat_wr_data", wr_data_seen,      32'h0000ABCD);
        chk("lat_wr_strb", 32'(wr_strb_seen), 32'hF);
        chk("lat_bresp",   32'(resp),         32'd0);

        // W one cycle ahead of AW
        w0 = wr_cnt;
        axi.s_axi_wdata = 32'h5; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_wvalid = 1'b0;
        axi.s_axi_awaddr = 4'h0; axi.s_axi_awvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0;
        done = -1;
        for (int i = 0; i < 20; i++) begin
            if (axi.s_axi_bvalid) begin done = cyc; break; end
            @(negedge clk);
        end
        chk("wfirst_bvalid_seen", 32'(done >= 0), 32'd1);
        chk("wfirst_bresp", 32'(axi.s_axi_bresp), 32'd0);
        @(negedge clk);
        $display("WR (W before AW) addr=0x0 data=0x00000005");
        chk("wfirst_wr_cnt",  32'(wr_cnt - w0),   32'd1);
        chk("wfirst_wr_addr", 32'(wr_addr_seen), 32'h0);
        chk("wfirst_wr_data", wr_data_seen,      32'h5);

        // Read back: rd_en two cycles after AR, rvalid four cycles after
        r0 = rd_cnt;
        do_read(4'h0, resp, rdat, hs, done);
        chk("lat_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        chk("lat_rd_cyc", 32'(rd_cyc - hs), 32'd2);
        chk("lat_r_cyc",  32'(done - hs),   32'd4);
        chk("lat_rdata",  rdat,             32'h5);
        chk("lat_rresp",  32'(resp),        32'd0);

        // Both pending after reset: write wins first
        ev_q.delete();
        axi.s_axi_awaddr = 4'h8; axi.s_axi_wdata = 32'h12345678; axi.s_axi_wstrb = 4'hF;
        axi.s_axi_araddr = 4'hC;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
        repeat (14) @(negedge clk);
        e0 = (ev_q.size() > 0) ? ev_q[0] : 9;
        e1 = (ev_q.size() > 1) ? ev_q[1] : 9;
        $display("ARB round1 order=%0d,%0d", e0, e1);
        chk("arb1_events", 32'(ev_q.size()), 32'd2);
        chk("arb1_first",  32'(e0), 32'd0);
        chk("arb1_second", 32'(e1), 32'd1);

        // Lone write makes write the last grant, so the next tie goes to read
        do_write(4'hC, 32'h0C0C0C0C, 4'hF, resp, hs, done);
        chk("arb_lone_bresp", 32'(resp), 32'd0);
        ev_q.delete();
        axi.s_axi_awaddr = 4'h8; axi.s_axi_wdata = 32'h12345678; axi.s_axi_wstrb = 4'hF;
        axi.s_axi_araddr = 4'hC;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
        repeat (14) @(negedge clk);
        e0 = (ev_q.size() > 0) ? ev_q[0] : 9;
        e1 = (ev_q.size() > 1) ? ev_q[1] : 9;
        $display("ARB round2 order=%0d,%0d", e0, e1);
        chk("arb2_events", 32'(ev_q.size()), 32'd2);
        chk("arb2_first",  32'(e0), 32'd1);
        chk("arb2_second", 32'(e1), 32'd0);

        // R-channel backpressure: rvalid/rdata stable, arready held low
        axi.s_axi_rready = 1'b0;
        axi.s_axi_araddr = 4'h4; axi.s_axi_arvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_arvalid = 1'b0;
        done = -1;
        for (int i = 0; i < 20; i++) begin
            if (axi.s_axi_rvalid) begin done = cyc; break; end
            @(negedge clk);
        end
        chk("bp_rvalid_seen", 32'(done >= 0), 32'd1);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("bp_rvalid_%0d", j),  32'(axi.s_axi_rvalid),  32'd1);
            chk($sformatf("bp_rdata_%0d", j),   axi.s_axi_rdata,        32'h0000ABCD);
            chk($sformatf("bp_arready_%0d", j), 32'(axi.s_axi_arready), 32'd0);
            @(negedge clk);
        end
        axi.s_axi_rready = 1'b1;
        @(negedge clk);
        $display("RD (backpressure) addr=0x4 rdata=0x0000ABCD");
        chk("bp_rvalid_drop", 32'(axi.s_axi_rvalid), 32'd0);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            if (!vecs[i].is_rd) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, hs, done);
                chk($sformatf("v%0d_bresp", i),  32'(resp),         32'(vecs[i].exp_resp));
                chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_access));
                if (vecs[i].exp_access) begin
                    chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr_seen), 32'(vecs[i].addr));
                    chk($sformatf("v%0d_wr_data", i), wr_data_seen,      vecs[i].data);
                    chk($sformatf("v%0d_wr_strb", i), 32'(wr_strb_seen), 32'(vecs[i].strb));
                end
            end else begin
                do_read(vecs[i].addr, resp, rdat, hs, done);
                chk($sformatf("v%0d_rresp", i),  32'(resp),         32'(vecs[i].exp_resp));
                chk($sformatf("v%0d_rdata", i),  rdat,              vecs[i].exp_rdata);
                chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt - r0), 32'(vecs[i].exp_access));
            end
        end
        chk("no_strobe_overlap", 32'(overlap), 32'd0);

        // Reset during WR_EXEC: everything drops at once, no write afterwards
        axi.s_axi_awaddr = 4'h4; axi.s_axi_wdata = 32'h99999999; axi.s_axi_wstrb = 4'hF;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
        @(negedge clk);
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        done = -1;
        for (int i = 0; i < 10; i++) begin
            if (bank_wr_en) begin done = cyc; break; end
            @(negedge clk);
        end
        chk("mid_wr_en_seen", 32'(done >= 0), 32'd1);
        rst_n = 1'b0;
        #1;
        snap = wr_cnt;
        chk("mid_bvalid",  32'(axi.s_axi_bvalid),  32'd0);
        chk("mid_rvalid",  32'(axi.s_axi_rvalid),  32'd0);
        chk("mid_wr_en",   32'(bank_wr_en),        32'd0);
        chk("mid_awready", 32'(axi.s_axi_awready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        $display("RST during WR_EXEC addr=0x4");
        chk("post_rst_wr_cnt", 32'(wr_cnt - snap),   32'd0);
        chk("post_rst_bvalid", 32'(axi.s_axi_bvalid), 32'd0);
        chk("post_rst_mem1",   mem[1],               32'h11223344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
